mfp_uart_loader_ctrl: RTL and testbench



---
 rtl/mfp_uart_loader_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mfp_uart_loader_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_uart_loader_ctrl.sv
// UART boot loader: turns a framed byte stream into 32-bit memory writes.
// Frame: header, ADDR x4, COUNT, COUNT*4 data bytes (MSB first), CSUM.
module mfp_uart_loader_ctrl #(
    parameter int unsigned timeout_cycles = 50000000,
    parameter logic [7:0]  header_byte    = 8'hA5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  byte_data,
    input  logic        byte_ready,
    output logic        write_valid,
    input  logic        write_ready,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        packet_done,
    output logic        error_checksum,
    output logic        error_overrun,
    output logic        error_timeout
);

    localparam int unsigned TW = $clog2(timeout_cycles + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_COUNT  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   shift_q, shift_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [8:0]    word_cnt_q, word_cnt_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wvalid_q, wvalid_d;
    logic [31:0]   waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          err_csum_q, err_csum_d;
    logic          err_ovr_q, err_ovr_d;
    logic          err_tmo_q, err_tmo_d;

    logic [7:0]    sum_add;
    logic          active;
    logic          timeout_hit;

    assign sum_add     = sum_q + byte_data;
    assign active      = state_q inside {S_ADDR, S_COUNT, S_DATA, S_CSUM};
    assign timeout_hit = active && !byte_ready
                         && (tmo_q == TW'(timeout_cycles - 1));

    // Next-state logic for the frame parser, write port and error flags.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        sum_d      = sum_q;
        wvalid_d   = wvalid_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_csum_d = err_csum_q;
        err_ovr_d  = err_ovr_q;
        err_tmo_d  = err_tmo_q;

        if (byte_ready || !active) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (wvalid_q && write_ready) begin
            wvalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (byte_ready && byte_data == header_byte) begin
                    state_d    = S_ADDR;
                    sum_d      = 8'h00;
                    byte_cnt_d = 2'd0;
                    err_csum_d = 1'b0;
                    err_ovr_d  = 1'b0;
                    err_tmo_d  = 1'b0;
                end
            end
            S_ADDR: begin
                if (byte_ready) begin
                    sum_d      = sum_add;
                    shift_d    = {shift_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        addr_d  = {shift_q[23:0], byte_data[7:2], 2'b00};
                        state_d = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                if (byte_ready) begin
                    sum_d      = sum_add;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = (byte_data == 8'h00) ? 9'd256
                                                      : {1'b0, byte_data};
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (byte_ready) begin
                    sum_d      = sum_add;
                    shift_d    = {shift_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Slot still occupied and not freed this edge:
                        // drop the new word and abandon the packet.
                        if (wvalid_q && !write_ready) begin
                            err_ovr_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            wvalid_d   = 1'b1;
                            waddr_d    = addr_q;
                            wdata_d    = {shift_q[23:0], byte_data};
                            addr_d     = addr_q + 32'd4;
                            word_cnt_d = word_cnt_q - 9'd1;
                            if (word_cnt_q == 9'd1) begin
                                state_d = S_CSUM;
                            end
                        end
                    end
                end
            end
            S_CSUM: begin
                if (byte_ready) begin
                    sum_d = sum_add;
                    if (sum_add == 8'h00) begin
                        state_d = S_FINISH;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_FINISH: begin
                if (!wvalid_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timeout_hit) begin
            err_tmo_d = 1'b1;
            state_d   = S_IDLE;
        end
    end

    // State registers; reset drops any pending write immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            sum_q      <= '0;
            tmo_q      <= '0;
            wvalid_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_csum_q <= 1'b0;
            err_ovr_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            wvalid_q   <= wvalid_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_csum_q <= err_csum_d;
            err_ovr_q  <= err_ovr_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    assign write_valid    = wvalid_q;
    assign write_address  = waddr_q;
    assign write_data     = wdata_q;
    assign busy           = (state_q != S_IDLE) | wvalid_q;
    assign packet_done    = done_q;
    assign error_checksum = err_csum_q;
    assign error_overrun  = err_ovr_q;
    assign error_timeout  = err_tmo_q;

endmodule

// File: tb/tb_mfp_uart_loader_ctrl.sv
// Bench for mfp_uart_loader_ctrl: scoreboard of expected memory writes.
// Frames are built here, expected writes queued as each word is sent.
module tb_mfp_uart_loader_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready = 1'b0;
    logic        write_valid;
    logic        write_ready = 1'b0;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        busy;
    logic        packet_done;
    logic        error_checksum;
    logic        error_overrun;
    logic        error_timeout;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t q[$];
    int  passed = 0;
    int  total = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  gap = 0;
    int  stall_n = 0;
    int  wcnt = 0;
    bit  hold_off = 1'b0;
    bit  acc_seen = 1'b0;

    mfp_uart_loader_ctrl #(
        .timeout_cycles(100),
        .header_byte(8'hA5)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .write_valid(write_valid),
        .write_ready(write_ready),
        .write_address(write_address),
        .write_data(write_data),
        .busy(busy),
        .packet_done(packet_done),
        .error_checksum(error_checksum),
        .error_overrun(error_overrun),
        .error_timeout(error_timeout)
    );

    always #5 clock = ~clock;

    // Memory-side responder: tied ready, stalled ready, or held off.
    always @(posedge clock) begin
        #1;
        if (!write_valid) wcnt = 0;
        else if (acc_seen) wcnt = 1;
        else wcnt++;
        acc_seen = 1'b0;
        if (hold_off) write_ready = 1'b0;
        else if (stall_n == 0) write_ready = 1'b1;
        else write_ready = write_valid && (wcnt > stall_n);
    end

    // Scoreboard: every presented write must match the queue head.
    always @(negedge clock) begin
        if (reset_n && write_valid) begin
            total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_write: addr %h data %h, none queued",
                         write_address, write_data);
            end else if (write_address !== q[0].a || write_data !== q[0].d) begin
                $display("FAIL write: got %h/%h want %h/%h",
                         write_address, write_data, q[0].a, q[0].d);
            end else begin
                passed++;
            end
            if (write_ready) begin
                if (q.size() != 0) void'(q.pop_front());
                wr_cnt++;
                acc_seen = 1'b1;
            end
        end
        if (packet_done) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick(gap);
        byte_data  = b;
        byte_ready = 1'b1;
        tick(1);
        byte_ready = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic send_packet(input logic [31:0] addr, input int nw,
                               input int nsend, input int npush,
                               input bit do_csum, input logic [7:0] cdelta);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] w;
        logic [31:0] a;
        sum = 8'h00;
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) begin
            b = addr[31-8*i -: 8];
            sum += b;
            send_byte(b);
        end
        b = nw[7:0];
        sum += b;
        send_byte(b);
        a = {addr[31:2], 2'b00};
        for (int k = 0; k < nsend; k++) begin
            w = $urandom;
            for (int j = 0; j < 4; j++) begin
                b = w[31-8*j -: 8];
                sum += b;
                if (j == 3 && k < npush) q.push_back('{a, w});
                send_byte(b);
            end
            a += 32'd4;
        end
        if (do_csum) send_byte(8'h00 - sum + cdelta);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        total++;
        if (!ok) $display("FAIL %s_idle: busy %b queued %0d, want idle",
                          name, busy, q.size());
        else passed++;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(2);
        total++;
        if ({write_valid, busy, packet_done, error_checksum, error_overrun,
             error_timeout} !== 6'b0 || write_address !== 32'h0
            || write_data !== 32'h0) begin
            $display("FAIL reset: wv %b busy %b addr %h data %h, want zeros",
                     write_valid, busy, write_address, write_data);
        end else passed++;
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_good_packet;
        logic [7:0] pk [10];
        logic [7:0] sum;
        int w0;
        int d0;
        pk = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01,
               8'hDE, 8'hAD, 8'hBE, 8'hEF};
        w0 = wr_cnt;
        d0 = done_cnt;
        gap = 1;
        sum = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) sum += pk[i];
            if (i == 9) q.push_back('{32'h0000_1000, 32'hDEAD_BEEF});
            send_byte(pk[i]);
        end
        send_byte(8'h00 - sum);
        total++;
        if (packet_done !== 1'b0) $display("FAIL done_early: got %b want 0", packet_done);
        else passed++;
        tick(1);
        total++;
        if (packet_done !== 1'b1 || busy !== 1'b0)
            $display("FAIL done_pulse: done %b busy %b want 1 0", packet_done, busy);
        else passed++;
        tick(1);
        total++;
        if (packet_done !== 1'b0) $display("FAIL done_width: got %b want 0", packet_done);
        else passed++;
        total++;
        if (wr_cnt - w0 != 1 || done_cnt - d0 != 1
            || {error_checksum, error_overrun, error_timeout} !== 3'b0)
            $display("FAIL good_pkt: writes %0d dones %0d errs %b want 1 1 000",
                     wr_cnt - w0, done_cnt - d0,
                     {error_checksum, error_overrun, error_timeout});
        else passed++;
    endtask

    task automatic test_stall;
        int  w0;
        bit  found;
        bit  prev_busy;
        w0 = wr_cnt;
        stall_n = 5;
        gap = 1;
        send_packet(32'h0000_0FFC, 3, 3, 3, 1'b1, 8'h00);
        found = 1'b0;
        prev_busy = busy;
        for (int i = 0; i < 300; i++) begin
            if (packet_done) begin
                found = 1'b1;
                break;
            end
            prev_busy = busy;
            tick(1);
        end
        total++;
        if (!found || busy !== 1'b0 || prev_busy !== 1'b1)
            $display("FAIL stall_done: found %b busy %b prev %b want 1 0 1",
                     found, busy, prev_busy);
        else passed++;
        total++;
        if (wr_cnt - w0 != 3) $display("FAIL stall_writes: got %0d want 3", wr_cnt - w0);
        else passed++;
        stall_n = 0;
        tick(2);
    endtask

    task automatic test_bad_checksum;
        int w0;
        int d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        gap = 1;
        send_packet(32'h0000_3000, 2, 2, 2, 1'b1, 8'h01);
        total++;
        if (error_checksum !== 1'b1) $display("FAIL csum_flag: got %b want 1", error_checksum);
        else passed++;
        wait_idle("csum");
        tick(3);
        total++;
        if (wr_cnt - w0 != 2 || done_cnt != d0)
            $display("FAIL csum_writes: writes %0d dones %0d want 2 0",
                     wr_cnt - w0, done_cnt - d0);
        else passed++;
        send_byte(8'hA5);
        total++;
        if (error_checksum !== 1'b0) $display("FAIL csum_clear: got %b want 0", error_checksum);
        else passed++;
        tick(110);
    endtask

    task automatic test_timeout;
        int w0;
        w0 = wr_cnt;
        gap = 0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        tick(98);
        total++;
        if (error_timeout !== 1'b0 || busy !== 1'b1)
            $display("FAIL tmo_early: err %b busy %b want 0 1", error_timeout, busy);
        else passed++;
        tick(2);
        total++;
        if (error_timeout !== 1'b1 || busy !== 1'b0 || wr_cnt != w0)
            $display("FAIL tmo_fire: err %b busy %b writes %0d want 1 0 0",
                     error_timeout, busy, wr_cnt - w0);
        else passed++;
    endtask

    task automatic test_overrun;
        int w0;
        w0 = wr_cnt;
        hold_off = 1'b1;
        gap = 1;
        send_packet(32'h0000_4000, 2, 2, 1, 1'b0, 8'h00);
        total++;
        if (error_overrun !== 1'b1 || write_valid !== 1'b1
            || write_address !== 32'h0000_4000)
            $display("FAIL ovr_flag: err %b wv %b addr %h want 1 1 00004000",
                     error_overrun, write_valid, write_address);
        else passed++;
        tick(3);
        hold_off = 1'b0;
        wait_idle("ovr");
        tick(10);
        total++;
        if (wr_cnt - w0 != 1) $display("FAIL ovr_writes: got %0d want 1", wr_cnt - w0);
        else passed++;
    endtask

    task automatic test_garbage_wrap;
        int w0;
        int d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        gap = 1;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        total++;
        if (busy !== 1'b0 || error_overrun !== 1'b1)
            $display("FAIL garbage: busy %b ovr %b want 0 1", busy, error_overrun);
        else passed++;
        send_packet(32'hFFFF_FFFE, 2, 2, 2, 1'b1, 8'h00);
        wait_idle("wrap");
        tick(3);
        total++;
        if (wr_cnt - w0 != 2 || done_cnt - d0 != 1
            || {error_checksum, error_overrun, error_timeout} !== 3'b0)
            $display("FAIL wrap: writes %0d dones %0d errs %b want 2 1 000",
                     wr_cnt - w0, done_cnt - d0,
                     {error_checksum, error_overrun, error_timeout});
        else passed++;
    endtask

    task automatic test_back_to_back;
        int w0;
        int d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        gap = 0;
        send_packet(32'h0000_8000, 256, 256, 256, 1'b1, 8'h00);
        wait_idle("b2b");
        tick(3);
        total++;
        if (wr_cnt - w0 != 256 || done_cnt - d0 != 1 || error_overrun !== 1'b0)
            $display("FAIL count256: writes %0d dones %0d ovr %b want 256 1 0",
                     wr_cnt - w0, done_cnt - d0, error_overrun);
        else passed++;
    endtask

    task automatic test_reset_mid;
        gap = 1;
        hold_off = 1'b1;
        send_packet(32'h0000_9000, 4, 1, 1, 1'b0, 8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        total++;
        if (write_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL mid_pending: wv %b busy %b want 1 1", write_valid, busy);
        else passed++;
        reset_n = 1'b0;
        #1;
        total++;
        if ({write_valid, busy, packet_done, error_checksum, error_overrun,
             error_timeout} !== 6'b0 || write_address !== 32'h0
            || write_data !== 32'h0)
            $display("FAIL mid_reset: wv %b busy %b addr %h data %h, want zeros",
                     write_valid, busy, write_address, write_data);
        else passed++;
        q.delete();
        hold_off = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        total++;
        if (busy !== 1'b0 || write_valid !== 1'b0)
            $display("FAIL post_reset: busy %b wv %b want 0 0", busy, write_valid);
        else passed++;
    endtask

    initial begin
        tick(1);
        test_reset();
        test_good_packet();
        test_stall();
        test_bad_checksum();
        test_timeout();
        test_overrun();
        test_garbage_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
